// File: rtl/sub_shift_rows.sv
`default_nettype none
// ============================================================================
//  Module   : sub_shift_rows
//  Purpose  : Iterative AES SubBytes + ShiftRows on the 128-bit column-major
//             state. COLS_PER_CYCLE columns are substituted per clock through
//             a shared bank of COLS_PER_CYCLE*4 S-box lookups, and each byte
//             is written straight to its row-shifted output position.
//  Option   : SUB_SHIFT_INV_EN adds i_inv, which selects InvSubBytes +
//             InvShiftRows for the block captured with it.
//  Revision : 1.0  initial release
// ============================================================================
module sub_shift_rows #(
   parameter int NB             = 4,
   parameter int WORD           = 8,
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_valid,
   output logic                   i_ready,
   input  logic [NB*NB*WORD-1:0]  i_block,
`ifdef SUB_SHIFT_INV_EN
   input  logic                   i_inv,
`endif
   output logic                   o_valid,
   output logic [NB*NB*WORD-1:0]  o_block
);

   localparam int BW = NB * NB * WORD;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   logic [0:0]      state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [BW-1:0]   in_q, in_d;
   logic [BW-1:0]   work_q, work_d;
   logic [BW-1:0]   o_block_q, o_block_d;
   logic            o_valid_q, o_valid_d;
`ifdef SUB_SHIFT_INV_EN
   logic            inv_q, inv_d;
`endif

   logic                              w_last;
   logic [COLS_PER_CYCLE*NB*WORD-1:0] w_sub;

   // Forward S-box: high nibble picks a 16-byte row, low nibble picks the byte.
   function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
      logic [127:0] row;
      logic [127:0] sel;
      case (x[7:4])
         4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
         4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
         4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
         4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
         4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
         4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
         4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
         4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
         4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
         4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
         4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
         4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
         4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
         4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
         4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
         default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
      endcase
      sel = row >> {~x[3:0], 3'b000};
      return sel[7:0];
   endfunction

`ifdef SUB_SHIFT_INV_EN
   // Inverse S-box, same row/byte organisation as the forward table.
   function automatic logic [7:0] sbox_inv(input logic [7:0] x);
      logic [127:0] row;
      logic [127:0] sel;
      case (x[7:4])
         4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
         4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
         4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
         4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
         4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
         4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
         4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
         4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
         4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
         4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
         4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
         4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
         4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
         4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
         4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
         default: row = 128'h172b047eba77d626e169146355210c7d;
      endcase
      sel = row >> {~x[3:0], 3'b000};
      return sel[7:0];
   endfunction
`endif

   // Final step of a block: the column counter has reached the last group.
   assign w_last = (cnt_q == 2'(NB - COLS_PER_CYCLE));

   // Shared S-box bank: lane j handles column cnt+j, one lookup per row.
   // Byte s[r][c] sits at LSB offset 8*(15-(4c+r)), i.e. {~{c,r},3'b000}.
   for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
      logic [1:0] w_col;
      assign w_col = cnt_q + 2'(j);
      for (genvar r = 0; r < NB; r++) begin : g_row
         logic [WORD-1:0] w_byte;
         assign w_byte = in_q[{~{w_col, 2'(r)}, 3'b000} +: WORD];
`ifdef SUB_SHIFT_INV_EN
         assign w_sub[(j*NB+r)*WORD +: WORD] = inv_q ? sbox_inv(w_byte) : sbox_fwd(w_byte);
`else
         assign w_sub[(j*NB+r)*WORD +: WORD] = sbox_fwd(w_byte);
`endif
      end
   end

   // State register and all datapath flops; asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         in_q      <= '0;
         work_q    <= '0;
         o_block_q <= '0;
         o_valid_q <= 1'b0;
`ifdef SUB_SHIFT_INV_EN
         inv_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         in_q      <= in_d;
         work_q    <= work_d;
         o_block_q <= o_block_d;
         o_valid_q <= o_valid_d;
`ifdef SUB_SHIFT_INV_EN
         inv_q     <= inv_d;
`endif
      end
   end

   // Next-state: accept in IDLE, return to IDLE after the last column group.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (i_valid) state_d = S_BUSY;
         S_BUSY:  if (w_last)  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake output: ready depends only on the state.
   always_comb begin
      i_ready = (state_q == S_IDLE);
   end

   // Datapath: capture on accept, scatter substituted bytes to their shifted
   // slots while busy, publish the whole result only on the final step.
   always_comb begin
      logic [1:0] col;
      logic [1:0] dst;
      col       = '0;
      dst       = '0;
      cnt_d     = cnt_q;
      in_d      = in_q;
      work_d    = work_q;
      o_block_d = o_block_q;
      o_valid_d = 1'b0;
`ifdef SUB_SHIFT_INV_EN
      inv_d     = inv_q;
`endif
      if (state_q == S_IDLE) begin
         if (i_valid) begin
            in_d  = i_block;
            cnt_d = '0;
`ifdef SUB_SHIFT_INV_EN
            inv_d = i_inv;
`endif
         end
      end else begin
         cnt_d = cnt_q + 2'(COLS_PER_CYCLE);
         for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            for (int r = 0; r < NB; r++) begin
               col = cnt_q + 2'(j);
`ifdef SUB_SHIFT_INV_EN
               dst = inv_q ? (col + 2'(r)) : (col - 2'(r));
`else
               dst = col - 2'(r);
`endif
               work_d[{~{dst, 2'(r)}, 3'b000} +: WORD] = w_sub[(j*NB+r)*WORD +: WORD];
            end
         end
         if (w_last) begin
            o_block_d = work_d;
            o_valid_d = 1'b1;
         end
      end
   end

   assign o_valid = o_valid_q;
   assign o_block = o_block_q;

endmodule
`default_nettype wire
